// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped write-through data cache:
//   - controller state encoding
//   - fixed field widths of the 32-bit address and data words
//   - byte-merge helper used for masked stores
// No ports (package).
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int XLEN   = 32;         // address and data word width
  localparam int OFF_W  = 2;          // byte-offset field, ignored by the cache
  localparam int MASK_W = XLEN / 8;   // one byte-enable per byte lane

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REFILL_REQ  = 2'd1,
    REFILL_WAIT = 2'd2,
    WRITE       = 2'd3
  } state_t;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [XLEN-1:0] merge_bytes(
    input logic [XLEN-1:0]   old_word,
    input logic [XLEN-1:0]   new_word,
    input logic [MASK_W-1:0] mask
  );
    logic [XLEN-1:0] res;
    res = old_word;
    for (int b = 0; b < MASK_W; b++) begin
      if (mask[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// -----------------------------------------------------------------------------
// dcache_array
// Tag, valid and data storage for the direct-mapped cache.
// Reads are combinational, writes are synchronous. Only the valid bits are
// reset; tag and data contents are meaningless until their valid bit is set.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (valid bits)
//   rd_index, rd_word     line and word selected by the current request
//   rd_valid, rd_tag      valid bit and stored tag of the selected line
//   rd_data               selected word of the selected line
//   data_we               write wr_data into (wr_index, wr_word) under wr_mask
//   tag_we                store wr_tag for wr_index and mark the line valid
//   inval                 clear the valid bit of wr_index
// -----------------------------------------------------------------------------
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(SETS),
  parameter int WORD_W     = $clog2(LINE_WORDS),
  parameter int TAG_W      = XLEN - OFF_W - WORD_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [XLEN-1:0]   rd_data,
  input  logic              data_we,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              inval
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [XLEN-1:0]  data_mem [SETS*LINE_WORDS];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_word}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[wr_index] <= 1'b1;
    end else if (inval) begin
      valid[wr_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{wr_index, wr_word}] <=
        merge_bytes(data_mem[{wr_index, wr_word}], wr_data, wr_mask);
    end
  end

endmodule

// File: rtl/dcache.sv
// -----------------------------------------------------------------------------
// dcache
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the MEM pipeline stage and a simple ready/valid memory port.
// Load hits complete in the request cycle; load misses refill the whole line
// and then complete as a hit; every store is written through to memory.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_ren/i_req_wen   load / store request (never both)
//   i_req_addr            byte address of the request
//   i_req_wdata/i_req_mask store data and byte enables
//   o_res_rdata           load data, valid when i_req_ren=1 and o_busy=0
//   o_busy                pipeline stall
//   o_mem_ren/o_mem_wen   memory read / write request
//   o_mem_addr            memory byte address
//   o_mem_wdata/o_mem_mask memory write data and byte enables
//   i_mem_ready           memory accepts the request this cycle
//   i_mem_valid/i_mem_rdata one refill word from memory
// -----------------------------------------------------------------------------
module dcache
  import dcache_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_ren,
  input  logic              i_req_wen,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  input  logic [MASK_W-1:0] i_req_mask,
  output logic [XLEN-1:0]   o_res_rdata,
  output logic              o_busy,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [MASK_W-1:0] o_mem_mask,
  input  logic              i_mem_ready,
  input  logic              i_mem_valid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = XLEN - OFF_W - WORD_W - IDX_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  state_t            state, state_nx;
  logic [WORD_W-1:0] cnt, cnt_nx;

  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic [XLEN-1:0]   line_addr;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [XLEN-1:0]   rd_data;
  logic              hit;

  logic              data_we;
  logic [WORD_W-1:0] wr_word;
  logic [XLEN-1:0]   wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              tag_we;
  logic              inval;

  logic              busy;
  logic              mem_ren;
  logic              mem_wen;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [MASK_W-1:0] mem_mask;

  assign req_word  = i_req_addr[OFF_W +: WORD_W];
  assign req_index = i_req_addr[OFF_W + WORD_W +: IDX_W];
  assign req_tag   = i_req_addr[XLEN-1 -: TAG_W];
  assign line_addr = {i_req_addr[XLEN-1:OFF_W+WORD_W], {(OFF_W+WORD_W){1'b0}}};

  assign hit = rd_valid && (rd_tag == req_tag);

  dcache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .WORD_W     (WORD_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .rd_index (req_index),
    .rd_word  (req_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .data_we  (data_we),
    .wr_index (req_index),
    .wr_word  (wr_word),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .tag_we   (tag_we),
    .wr_tag   (req_tag),
    .inval    (inval)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    busy      = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    data_we   = 1'b0;
    wr_word   = req_word;
    wr_data   = i_req_wdata;
    wr_mask   = i_req_mask;
    tag_we    = 1'b0;
    inval     = 1'b0;

    case (state)
      IDLE: begin
        if (i_req_wen) begin
          busy     = 1'b1;
          state_nx = WRITE;
        end else if (i_req_ren && !hit) begin
          // The victim line is invalidated up front so a refill that never
          // finishes cannot leave a half-overwritten line marked valid.
          busy     = 1'b1;
          inval    = 1'b1;
          cnt_nx   = '0;
          state_nx = REFILL_REQ;
        end
      end

      REFILL_REQ: begin
        busy     = 1'b1;
        mem_ren  = 1'b1;
        mem_addr = line_addr;
        if (i_mem_ready) begin
          state_nx = REFILL_WAIT;
        end
      end

      REFILL_WAIT: begin
        busy = 1'b1;
        if (i_mem_valid) begin
          data_we = 1'b1;
          wr_word = cnt;
          wr_data = i_mem_rdata;
          wr_mask = '1;
          cnt_nx  = cnt + 1'b1;
          if (cnt == LAST_WORD) begin
            tag_we   = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end
      end

      WRITE: begin
        busy      = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = i_req_addr;
        mem_wdata = i_req_wdata;
        mem_mask  = i_req_mask;
        if (i_mem_ready) begin
          // Write-through: the cached copy is patched only if it is present,
          // and only on the cycle memory takes the store.
          data_we  = hit;
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of the request.
  assign o_busy      = i_rst_n & busy;
  assign o_mem_ren   = i_rst_n & mem_ren;
  assign o_mem_wen   = i_rst_n & mem_wen;
  assign o_mem_addr  = i_rst_n ? mem_addr  : '0;
  assign o_mem_wdata = i_rst_n ? mem_wdata : '0;
  assign o_mem_mask  = i_rst_n ? mem_mask  : '0;
  assign o_res_rdata = i_rst_n ? rd_data   : '0;

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;

  localparam int SETS       = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ren   = 1'b0;
  logic        wen   = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask  = '0;
  logic [31:0] o_res_rdata;
  logic        o_busy;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        mem_ready = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  dcache #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_ren   (ren),
    .i_req_wen   (wen),
    .i_req_addr  (addr),
    .i_req_wdata (wdata),
    .i_req_mask  (mask),
    .o_res_rdata (o_res_rdata),
    .o_busy      (o_busy),
    .o_mem_ren   (o_mem_ren),
    .o_mem_wen   (o_mem_wen),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_mask  (o_mem_mask),
    .i_mem_ready (mem_ready),
    .i_mem_valid (mem_valid),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Backing memory: written words live in the array, others follow a pattern.
  logic [31:0] mem [bit [31:0]];
  int  rdy_wait  = 2;
  bit  gap_en    = 1'b0;
  bit  noise_en  = 1'b0;
  int  rd_acc    = 0;
  int  wr_acc    = 0;
  int  excl_viol = 0;
  logic [31:0] rd_acc_addr = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    bit [31:0] k;
    k = a >> 2;
    if (mem.exists(k)) return mem[k];
    return {a[31:2], 2'b00} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    bit [31:0] k;
    k = a >> 2;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mem[k] = w;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory responder: ready after rdy_wait request cycles, then a line of words.
  initial begin
    int phase = 0;
    int cnt   = 0;
    int w     = 0;
    logic [31:0] line = '0;
    forever begin
      @(posedge clk); #2;
      mem_ready = 1'b0;
      mem_valid = 1'b0;
      mem_rdata = $urandom;
      if (!rst_n) begin
        phase = 0;
        cnt   = 0;
      end else if (phase == 1) begin
        if (!(gap_en && $urandom_range(0, 2) == 0)) begin
          mem_valid = 1'b1;
          mem_rdata = mem_rd(line + 32'(4 * w));
          w++;
          if (w == LINE_WORDS) phase = 0;
        end
      end else if (o_mem_ren || o_mem_wen) begin
        if (cnt >= rdy_wait) begin
          mem_ready = 1'b1;
          cnt = 0;
          if (o_mem_ren) begin
            phase = 1;
            w     = 0;
            line  = o_mem_addr;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      if (noise_en && !mem_valid && (phase == 0 || mem_ready) && $urandom_range(0, 1) == 0)
        mem_valid = 1'b1;
    end
  end

  // Transaction monitor.
  initial begin
    forever begin
      @(posedge clk); #3;
      if (o_mem_ren && o_mem_wen) excl_viol++;
      if (o_mem_ren && mem_ready) begin
        rd_acc++;
        rd_acc_addr = o_mem_addr;
      end
      if (o_mem_wen && mem_ready) wr_acc++;
    end
  end

  task automatic do_load(input logic [31:0] a, output bit hit, output logic [31:0] d);
    bit done = 1'b0;
    int bc   = 0;
    d = '0;
    @(posedge clk); #1;
    ren = 1'b1; addr = a;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        done = 1'b1;
        d    = o_res_rdata;
      end else begin
        bc++;
        @(posedge clk); #1;
      end
    end
    ren = 1'b0;
    chk("load_done", 32'(done), 32'd1);
    hit = (bc == 0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int bc);
    bit done = 1'b0;
    bc = 0;
    @(posedge clk); #1;
    wen = 1'b1; addr = a; wdata = d; mask = m;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (o_busy) bc++;
      if (o_mem_wen && mem_ready) begin
        done = 1'b1;
        chk("st_addr", o_mem_addr, a);
        chk("st_data", o_mem_wdata, d);
        chk("st_mask", 32'(o_mem_mask), 32'(m));
      end
      @(posedge clk); #1;
    end
    wen = 1'b0;
    chk("store_done", 32'(done), 32'd1);
    if (done) mem_wr(a, d, m);
  endtask

  typedef struct {
    bit          st;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    bit          exp_hit;
    logic [31:0] exp_d;
  } vec_t;

  initial begin
    vec_t vecs [10];
    bit          hit;
    logic [31:0] d;
    int          bc, rd0, wr0, words;
    int          ref_line [SETS];

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h0000_00A0};
    vecs[1] = '{1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1, 32'h0000_00A1};
    vecs[2] = '{1'b0, 32'h0000_010C, 32'h0, 4'h0, 1'b1, 32'h0000_00A3};
    vecs[3] = '{1'b1, 32'h0000_0108, 32'h1122_3344, 4'b0011, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0108, 32'h0, 4'h0, 1'b1, 32'h0000_3344};
    vecs[5] = '{1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_2000, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'h0000_00A0};
    vecs[8] = '{1'b0, 32'h0000_0100 + SETS*LINE_BYTES, 32'h0, 4'h0, 1'b0, 32'h5A5A_A6A5};
    vecs[9] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h0000_00A0};

    for (int k = 0; k < LINE_WORDS; k++) mem[32'((32'h100 >> 2) + k)] = 32'hA0 + 32'(k);

    // Reset state, with a would-be miss presented during reset.
    ren = 1'b1; addr = 32'h100;
    #12;
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_mren",  32'(o_mem_ren), 32'd0);
    chk("rst_mwen",  32'(o_mem_wen), 32'd0);
    chk("rst_maddr", o_mem_addr, 32'd0);
    chk("rst_rdata", o_res_rdata, 32'd0);
    @(posedge clk); #1;
    ren = 1'b0; rst_n = 1'b1;

    // Directed table.
    rdy_wait = 2;
    for (int i = 0; i < 10; i++) begin
      rd0 = rd_acc; wr0 = wr_acc;
      if (vecs[i].st) begin
        do_store(vecs[i].a, vecs[i].d, vecs[i].m, bc);
        chk($sformatf("v%0d_st_busy", i), 32'(bc), 32'd4);
        chk($sformatf("v%0d_no_refill", i), 32'(rd_acc - rd0), 32'd0);
        chk($sformatf("v%0d_one_write", i), 32'(wr_acc - wr0), 32'd1);
      end else begin
        do_load(vecs[i].a, hit, d);
        chk($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
        chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_d);
        chk($sformatf("v%0d_reads", i), 32'(rd_acc - rd0), vecs[i].exp_hit ? 32'd0 : 32'd1);
        if (!vecs[i].exp_hit)
          chk($sformatf("v%0d_refill_addr", i), rd_acc_addr, vecs[i].a & ~32'(LINE_BYTES - 1));
      end
    end

    // Reset pulse after the second refill word of a fresh line.
    @(posedge clk); #1;
    ren = 1'b1; addr = 32'h340; words = 0;
    for (int i = 0; i < 100 && words < 2; i++) begin
      @(negedge clk);
      if (mem_valid) words++;
      @(posedge clk); #1;
    end
    chk("rst_mid_words", 32'(words), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    chk("rst_mid_mren", 32'(o_mem_ren), 32'd0);
    chk("rst_mid_rdata", o_res_rdata, 32'd0);
    @(posedge clk); #1;
    ren = 1'b0; rst_n = 1'b1;
    do_load(32'h340, hit, d);
    chk("after_rst_340_hit", 32'(hit), 32'd0);
    chk("after_rst_340_data", d, 32'h340 ^ 32'h5A5A_A5A5);
    do_load(32'h2000, hit, d);
    chk("after_rst_2000_hit", 32'(hit), 32'd0);
    do_load(32'h100, hit, d);
    chk("after_rst_100_hit", 32'(hit), 32'd0);
    chk("after_rst_100_data", d, 32'hA0);

    // Randomized traffic against a line-occupancy model.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < SETS; s++) ref_line[s] = -1;
    gap_en = 1'b1; noise_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      int tg, ix, wd, line;
      logic [31:0] a, dd;
      logic [3:0]  mm;
      rdy_wait = $urandom_range(0, 3);
      tg = $urandom_range(0, 3);
      ix = $urandom_range(0, 3);
      wd = $urandom_range(0, LINE_WORDS - 1);
      a  = 32'h4000 + 32'(((tg * SETS + ix) * LINE_WORDS + wd) * 4);
      line = int'(a / LINE_BYTES);
      if ($urandom_range(0, 2) == 0) begin
        dd = $urandom;
        mm = 4'($urandom_range(1, 15));
        do_store(a, dd, mm, bc);
        chk("rnd_st_busy", 32'(bc), 32'(rdy_wait + 2));
      end else begin
        a = a + 32'($urandom_range(0, 3));
        do_load(a, hit, d);
        chk("rnd_hit", 32'(hit), 32'(ref_line[line % SETS] == line));
        chk("rnd_rdata", d, mem_rd(a));
        ref_line[line % SETS] = line;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle_busy", 32'(o_busy), 32'd0);
      end
    end

    chk("mem_exclusive", 32'(excl_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
